aes_round_seq: RTL

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq: control sequencer for an iterative AES-128 style datapath.
// It walks LOAD -> ADD0 -> {SUB, SHI, MIX, ADD} x ROUNDS -> FIN. The final
// round leaves out MIX. The round constant is produced on the fly by GF(2^8)
// doubling and is presented to the key expander together with key_step in SUB.
// Optional feature: define AES_ABORT_EN to add an 'abort' input. When it is
// high in any non-IDLE state, the sequencer cancels the block in flight.
module aes_round_seq #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
`ifdef AES_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       load_en,
  output logic [3:0] stage,
  output logic       key_step,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ADD0 = 3'd2,
    SUB  = 3'd3,
    SHI  = 3'd4,
    MIX  = 3'd5,
    ADD  = 3'd6,
    FIN  = 3'd7
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rc_q, rc_d;
  logic       abort_req;

  // Multiplication by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // State, round counter and round-constant registers; async active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rc_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rc_q    <= rc_d;
    end
  end

  // Next-state logic. Abort overrides every other transition.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    rc_d      = rc_q;
`ifdef AES_ABORT_EN
    abort_req = abort;
`else
    abort_req = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        round_d = 4'd0;
        if (start) state_d = LOAD;
      end
      LOAD: state_d = ADD0;
      ADD0: begin
        state_d = SUB;
        round_d = 4'd1;
        rc_d    = 8'h01;
      end
      SUB:  state_d = SHI;
      SHI:  state_d = (round_q < LAST_ROUND) ? MIX : ADD;
      MIX:  state_d = ADD;
      ADD: begin
        if (round_q < LAST_ROUND) begin
          state_d = SUB;
          round_d = round_q + 4'd1;
          rc_d    = xtime(rc_q);
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        // round stays at its final value until the consumer acknowledges
        if (ack) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
    if (abort_req && (state_q != IDLE)) begin
      state_d = IDLE;
      round_d = 4'd0;
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    busy      = (state_q != IDLE);
    load_en   = (state_q == LOAD);
    key_step  = (state_q == SUB);
    rcon      = (state_q == SUB) ? rc_q : 8'h00;
    round     = round_q;
    out_valid = (state_q == FIN);
    case (state_q)
      ADD0, ADD: stage = 4'b1000;
      MIX:       stage = 4'b0100;
      SHI:       stage = 4'b0010;
      SUB:       stage = 4'b0001;
      default:   stage = 4'b0000;
    endcase
  end

endmodule
